// File: rtl/fifo_ctrl_pkg.sv
// Shared types and constants for the sync_fifo write-side control blocks.
package fifo_ctrl_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_NUM_REQ = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Ceiling log2, never smaller than 1, so that it can size index
    // and counter vectors even when the count is 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) r = r + 1;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: finds the first set request at or after
// start_i, wrapping modulo N.
module rr_pick
    import fifo_ctrl_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]          req_i,
    input  logic [clog2(N)-1:0]   start_i,
    output logic                  found_o,
    output logic [clog2(N)-1:0]   idx_o
);

    localparam int IW = clog2(N);

    // Walk the candidates from farthest to nearest so the nearest hit wins.
    always_comb begin
        int c;
        c       = 0;
        found_o = 1'b0;
        idx_o   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            c = int'(start_i) + k;
            if (c >= N) c = c - N;
            if (req_i[c]) begin
                found_o = 1'b1;
                idx_o   = IW'(c);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the sync_fifo write port among NUM_REQ
// valid/ready producers. One owner at a time, at most MAX_BURST writes
// per grant, one arbitration bubble per grant.
module fifo_wr_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_BURST = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       fifo_full,
    output logic                       fifo_wn,
    output logic [WIDTH-1:0]           fifo_datain,
    output logic [clog2(NUM_REQ)-1:0]  grant_id,
    output logic                       busy
);

    localparam int IW = clog2(NUM_REQ);
    localparam int CW = clog2(MAX_BURST);
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);

    arb_state_e    state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] burst_cnt_q, burst_cnt_d;

    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic          own_valid;
    logic [IW-1:0] owner_next;

    logic [WIDTH-1:0] lane_data [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
        assign lane_data[g] = req_data[g*WIDTH +: WIDTH];
    end

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req_i   (req_valid),
        .start_i (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign own_valid  = req_valid[owner_q];
    assign owner_next = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
    assign busy       = (state_q == BUSY);
    assign grant_id   = busy ? owner_q : '0;

    // State, owner, burst counter and rotation pointer registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // Next-state and write-port outputs; the write path is combinational
    // so a full FIFO blocks the write in the same cycle.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        req_ready   = '0;
        fifo_wn     = 1'b0;
        fifo_datain = '0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    owner_d     = pick_idx;
                    burst_cnt_d = '0;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                req_ready[owner_q] = ~fifo_full;
                fifo_wn            = own_valid & ~fifo_full;
                if (fifo_wn) fifo_datain = lane_data[owner_q];
                // Owner gone, or last beat of the burst: hand the port on.
                // A full FIFO with the owner still valid just holds.
                if (!own_valid || (!fifo_full && burst_cnt_q == LAST_BEAT)) begin
                    state_d     = IDLE;
                    rr_ptr_d    = owner_next;
                    burst_cnt_d = '0;
                end else if (!fifo_full) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed vector bench for fifo_wr_arbiter (NUM_REQ=4, MAX_BURST=4).
// Each vector gives one cycle's inputs and the outputs expected in that
// cycle, before the clock edge that consumes them.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int MB = 4;

    logic           clock = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           fifo_full;
    logic           fifo_wn;
    logic [W-1:0]   fifo_datain;
    logic [1:0]     grant_id;
    logic           busy;

    always #5 clock = ~clock;

    fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fifo_full   (fifo_full),
        .fifo_wn     (fifo_wn),
        .fifo_datain (fifo_datain),
        .grant_id    (grant_id),
        .busy        (busy)
    );

    typedef struct {
        logic         rst;
        logic [N-1:0] vld;
        logic         full;
        logic [W-1:0] d;      // data on the expected owner's lane
        logic [N-1:0] e_rdy;
        logic         e_wn;
        logic [1:0]   e_gid;
        logic         e_busy;
    } vec_t;

    vec_t vq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic push(input logic rst, input logic [N-1:0] vld, input logic full,
                        input logic [W-1:0] d, input logic [N-1:0] e_rdy,
                        input logic e_wn, input logic [1:0] e_gid, input logic e_busy);
        vec_t v;
        v.rst = rst; v.vld = vld; v.full = full; v.d = d;
        v.e_rdy = e_rdy; v.e_wn = e_wn; v.e_gid = e_gid; v.e_busy = e_busy;
        vq.push_back(v);
    endtask

    task automatic idle(input logic [N-1:0] vld);
        push(1'b0, vld, 1'b0, '0, '0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic wr(input logic [N-1:0] vld, input int o, input logic [W-1:0] d);
        push(1'b0, vld, 1'b0, d, N'(1 << o), 1'b1, 2'(o), 1'b1);
    endtask

    // Owner o sees valid low: ready still reflects ~full, no write.
    task automatic drop(input logic [N-1:0] vld, input int o);
        push(1'b0, vld, 1'b0, '0, N'(1 << o), 1'b0, 2'(o), 1'b1);
    endtask

    task automatic chk(input int idx, input string nm, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL vec %0d %s: got %h want %h", idx, nm, got, exp);
        end
    endtask

    initial begin
        logic [W-1:0] exp_d;
        int           writes;

        // ---- vector table ----
        // Reset held with everyone valid, then first grant goes to 0.
        push(1'b1, 4'b1111, 1'b0, '0, '0, 1'b0, 2'd0, 1'b0);
        push(1'b1, 4'b1111, 1'b0, '0, '0, 1'b0, 2'd0, 1'b0);
        idle(4'b1111);
        // Round robin 0,1,2,3 with 4 writes each and a bubble between.
        for (int o = 0; o < N; o++) begin
            for (int k = 0; k < MB; k++) wr(4'b1111, o, W'(32'h100 * o + k));
            idle(4'b1111);
        end
        wr(4'b1111, 0, 32'h0000_0004);     // wraps back to 0
        drop(4'b0000, 0);                   // release, rr_ptr -> 1
        idle(4'b0000);
        // Reset during req1's second write; pointer must return to 0.
        idle(4'b0010);
        wr(4'b0010, 1, 32'h11);
        push(1'b1, 4'b0010, 1'b0, 32'h12, 4'b0010, 1'b1, 2'd1, 1'b1);
        idle(4'b0011);
        wr(4'b0011, 0, 32'h20);
        drop(4'b0000, 0);                   // rr_ptr -> 1
        idle(4'b0000);
        // Single requester: 10,15,20,30 | bubble | 35,40,45.
        idle(4'b0010);
        wr(4'b0010, 1, 32'd10); wr(4'b0010, 1, 32'd15);
        wr(4'b0010, 1, 32'd20); wr(4'b0010, 1, 32'd30);
        idle(4'b0010);
        wr(4'b0010, 1, 32'd35); wr(4'b0010, 1, 32'd40); wr(4'b0010, 1, 32'd45);
        drop(4'b0000, 1);                   // rr_ptr -> 2
        idle(4'b0000);
        // Full stall on req2 after 2 writes; 2 more writes then release.
        idle(4'b0100);
        wr(4'b0100, 2, 32'h31); wr(4'b0100, 2, 32'h32);
        for (int k = 0; k < 3; k++)
            push(1'b0, 4'b0100, 1'b1, 32'h33, 4'b0000, 1'b0, 2'd2, 1'b1);
        wr(4'b0100, 2, 32'h33); wr(4'b0100, 2, 32'h34);
        idle(4'b0100);                      // released after 4th write
        drop(4'b0000, 2);                   // rr_ptr -> 3
        idle(4'b0000);
        // Early release by req0; search restarts at 1, so req3 beats req0.
        idle(4'b0001);
        wr(4'b1001, 0, 32'h41);
        drop(4'b1000, 0);                   // rr_ptr -> 1
        idle(4'b1001);
        wr(4'b1001, 3, 32'h51);
        drop(4'b0000, 3);                   // rr_ptr -> 0
        idle(4'b0000);

        // ---- apply ----
        reset = 1'b1; req_valid = '0; req_data = '0; fifo_full = 1'b0;
        @(posedge clock); #1;
        foreach (vq[i]) begin
            reset     = vq[i].rst;
            req_valid = vq[i].vld;
            fifo_full = vq[i].full;
            for (int l = 0; l < N; l++)
                req_data[l*W +: W] = (vq[i].e_busy && vq[i].e_gid == 2'(l))
                                     ? vq[i].d : (32'hDEAD_0000 | W'(l));
            #2;
            exp_d = vq[i].e_wn ? vq[i].d : '0;
            chk(i, "req_ready", W'(req_ready), W'(vq[i].e_rdy));
            chk(i, "fifo_wn",   W'(fifo_wn),   W'(vq[i].e_wn));
            chk(i, "fifo_datain", fifo_datain, exp_d);
            chk(i, "grant_id",  W'(grant_id),  W'(vq[i].e_gid));
            chk(i, "busy",      W'(busy),      W'(vq[i].e_busy));
            @(posedge clock); #1;
        end

        // ---- hand sequence: random full against continuous demand ----
        writes = 0;
        req_valid = '1;
        for (int c = 0; c < 80; c++) begin
            fifo_full = 1'($urandom_range(0, 1));
            for (int l = 0; l < N; l++) req_data[l*W +: W] = W'($urandom);
            #2;
            if (fifo_wn) writes++;
            if (fifo_full) chk(1000 + c, "wn_while_full", W'(fifo_wn), '0);
            @(posedge clock); #1;
        end
        n_cmp++;
        if (writes == 0) begin
            n_bad++;
            $display("FAIL random_writes: got %0d want >0", writes);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter sharing the single write port of sync_fifo (wn/datain/full) among NUM_REQ producers.
- Each producer uses a valid/ready handshake. The arbiter grants one owner at a time, for a bounded burst, and drives wn/datain directly into sync_fifo.
- Sits between producer blocks and the sync_fifo write side. The read side of the FIFO is untouched.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 32, data width; matches sync_fifo datain
- MAX_BURST, 4, max consecutive writes per grant (>=1)

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester write request
- req_data  input  NUM_REQ*WIDTH  flattened data; requester i occupies bits [i*WIDTH +: WIDTH]
- req_ready  output  NUM_REQ  per-requester accept; transfer = valid & ready
- fifo_full  input  1  sync_fifo full flag
- fifo_wn  output  1  sync_fifo write enable
- fifo_datain  output  WIDTH  sync_fifo write data
- grant_id  output  clog2(NUM_REQ)  current owner index; 0 when idle
- busy  output  1  1 while a grant is held

Behaviour:
- Reset is synchronous and active-high. After the edge with reset=1:
  - state=IDLE, rr_ptr=0, burst_cnt=0, grant_id=0, busy=0
  - req_ready=0, fifo_wn=0, fifo_datain=0
- Reset mid-burst aborts the burst. The FIFO contents are not the arbiter's concern.
- States: IDLE, BUSY. state, owner, burst_cnt and rr_ptr are registered.
- IDLE:
  - req_ready=0, fifo_wn=0.
  - If any req_valid: owner <= first i with valid=1, searching rr_ptr, rr_ptr+1, ... mod NUM_REQ. Then burst_cnt<=0, go to BUSY.
  - Arbitration latency is 1 cycle, so there is one bubble per grant.
- BUSY:
  - req_ready[owner] = ~fifo_full. All other req_ready bits are 0.
  - fifo_wn = req_valid[owner] & ~fifo_full, combinational.
  - fifo_datain = owner's data when fifo_wn=1, else 0.
  - On a transfer: burst_cnt++.
    - If burst_cnt == MAX_BURST-1: release.
  - req_valid[owner]=0: release that cycle, with no write.
  - fifo_full=1 with owner valid: hold the grant, no write, burst_cnt unchanged. There is no timeout.
  - Release means: state<=IDLE, rr_ptr<=(owner+1) mod NUM_REQ, burst_cnt<=0.
- Overflow safety: fifo_wn is never 1 while fifo_full=1.
- Fairness: a requester that stays valid is granted within (NUM_REQ-1)*(MAX_BURST+1)+1 cycles of the full-free arbiter cycles.
- Non-owners' valid and data are ignored and need not be held stable. The owner must hold data stable while valid=1 and ready=0.
- Simultaneous release and new requests: the new owner is picked in the following IDLE cycle using the updated rr_ptr.
- grant_id = owner when busy=1, else 0.

Decomposition:
- Package fifo_ctrl_pkg:
  - state typedef {IDLE, BUSY}
  - clog2 helper function
  - default WIDTH/NUM_REQ constants, shared with sync_fifo users
- Sub-module rr_pick: combinational rotate-priority encoder.
  - Inputs: req vector, start pointer.
  - Outputs: found flag, index.
  - Reused by future read-side schedulers.

Test Plan:
- Reset check: assert reset for 2 cycles with all req_valid=1 → req_ready=0, fifo_wn=0, busy=0, grant_id=0. One cycle after release: busy=1, grant_id=0.
- Single requester: req1 valid, data 10, 15, 20, 30, 35, 40, 45, MAX_BURST=4.
  - FIFO receives 10, 15, 20, 30.
  - Then 1 idle cycle, req1 regranted (only requester).
  - Then 35, 40, 45.
  - Total 7 writes, 2 bubbles.
- Round-robin rotation: all 4 valid continuously with data 0x100*i+k → grant order 0,1,2,3,0. Each grant gives exactly 4 writes, separated by one cycle with fifo_wn=0.
- Full stall: owner req2 mid-burst after 2 writes, fifo_full=1 for 3 cycles.
  - During the stall: fifo_wn=0, req_ready[2]=0, grant held, burst_cnt=2.
  - After full drops: exactly 2 more writes, then release.
- Early release: owner req0 drops valid after 1 write while req3 is valid → next owner is req3 (search from rr_ptr=1), not req0.
- Reset mid-burst: reset during req1's 2nd write. Next cycle: idle, rr_ptr=0. Then with req0 and req1 both valid, req0 is granted first.
